// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Forward-select encodings match the EX operand mux wiring.
package hazard_pkg;

    localparam int REG_W_DEFAULT = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic                     valid;
        logic [REG_W_DEFAULT-1:0] dest;
        logic                     reg_write;
        logic                     mem_read;
    } stage_t;

endpackage

// File: rtl/hazard_forward_ctrl_reg_hit.sv
// Register-hit comparator: a live writer in some stage targets a source operand
// that the consumer actually reads. The zero register never matches.
module reg_hit #(
    parameter int               REG_W     = 5,
    parameter logic [REG_W-1:0] NREG_ZERO = '0
) (
    input  logic             valid,
    input  logic             reg_write,
    input  logic [REG_W-1:0] dest,
    input  logic [REG_W-1:0] src,
    input  logic             used,
    output logic             hit
);

    assign hit = valid & reg_write & used & (dest != NREG_ZERO) & (dest == src);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: tracks EX/MEM/WB
// writers, drives EX and ID forward selects, and stalls on load-use/branch-use.
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int               REG_W     = REG_W_DEFAULT,
    parameter logic [REG_W-1:0] NREG_ZERO = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_branch,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             id_fwd_a,
    output logic             id_fwd_b
);

    stage_t           ex_q;
    stage_t           mem_q;
    logic [REG_W-1:0] ex_rs;
    logic [REG_W-1:0] ex_rt;
    logic             wb_valid;
    logic [REG_W-1:0] wb_dest;
    logic             wb_reg_write;

    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;

    // ID operands against the writers in EX and MEM
    reg_hit #(.REG_W(REG_W), .NREG_ZERO(NREG_ZERO)) u_ex_rs (.valid(ex_q.valid), .reg_write(ex_q.reg_write), .dest(ex_q.dest), .src(id_rs), .used(id_use_rs), .hit(ex_hit_rs));
    reg_hit #(.REG_W(REG_W), .NREG_ZERO(NREG_ZERO)) u_ex_rt (.valid(ex_q.valid), .reg_write(ex_q.reg_write), .dest(ex_q.dest), .src(id_rt), .used(id_use_rt), .hit(ex_hit_rt));
    reg_hit #(.REG_W(REG_W), .NREG_ZERO(NREG_ZERO)) u_mem_rs (.valid(mem_q.valid), .reg_write(mem_q.reg_write), .dest(mem_q.dest), .src(id_rs), .used(id_use_rs), .hit(mem_hit_rs));
    reg_hit #(.REG_W(REG_W), .NREG_ZERO(NREG_ZERO)) u_mem_rt (.valid(mem_q.valid), .reg_write(mem_q.reg_write), .dest(mem_q.dest), .src(id_rt), .used(id_use_rt), .hit(mem_hit_rt));

    // EX operands against MEM and WB; unused EX operands were parked on the zero register
    reg_hit #(.REG_W(REG_W), .NREG_ZERO(NREG_ZERO)) u_mem_a (.valid(mem_q.valid), .reg_write(mem_q.reg_write), .dest(mem_q.dest), .src(ex_rs), .used(ex_q.valid), .hit(mem_hit_a));
    reg_hit #(.REG_W(REG_W), .NREG_ZERO(NREG_ZERO)) u_mem_b (.valid(mem_q.valid), .reg_write(mem_q.reg_write), .dest(mem_q.dest), .src(ex_rt), .used(ex_q.valid), .hit(mem_hit_b));
    reg_hit #(.REG_W(REG_W), .NREG_ZERO(NREG_ZERO)) u_wb_a (.valid(wb_valid), .reg_write(wb_reg_write), .dest(wb_dest), .src(ex_rs), .used(ex_q.valid), .hit(wb_hit_a));
    reg_hit #(.REG_W(REG_W), .NREG_ZERO(NREG_ZERO)) u_wb_b (.valid(wb_valid), .reg_write(wb_reg_write), .dest(wb_dest), .src(ex_rt), .used(ex_q.valid), .hit(wb_hit_b));

    always_comb begin
        stall    = id_valid & (((ex_q.mem_read | id_branch) & (ex_hit_rs | ex_hit_rt)) |
                               (id_branch & mem_q.mem_read & (mem_hit_rs | mem_hit_rt)));
        id_fwd_a = id_branch & mem_hit_rs & ~mem_q.mem_read;
        id_fwd_b = id_branch & mem_hit_rt & ~mem_q.mem_read;

        // A load in MEM is never a forward source; the stall already pushed it to WB
        fwd_a = FWD_REG;
        if (mem_hit_a & ~mem_q.mem_read) fwd_a = FWD_MEM;
        else if (wb_hit_a)               fwd_a = FWD_WB;

        fwd_b = FWD_REG;
        if (mem_hit_b & ~mem_q.mem_read) fwd_b = FWD_MEM;
        else if (wb_hit_b)               fwd_b = FWD_WB;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_q         <= '0;
            mem_q        <= '0;
            ex_rs        <= NREG_ZERO;
            ex_rt        <= NREG_ZERO;
            wb_valid     <= 1'b0;
            wb_dest      <= '0;
            wb_reg_write <= 1'b0;
        end else begin
            wb_valid       <= mem_q.valid;
            wb_dest        <= mem_q.dest;
            wb_reg_write   <= mem_q.reg_write;
            mem_q          <= ex_q;
            ex_q.valid     <= id_valid & ~stall & ~flush;
            ex_q.dest      <= id_dest;
            ex_q.reg_write <= id_reg_write;
            ex_q.mem_read  <= id_mem_read;
            ex_rs          <= id_use_rs ? id_rs : NREG_ZERO;
            ex_rt          <= id_use_rt ? id_rt : NREG_ZERO;
        end
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: cycle-by-cycle vector table with hand-derived
// expected outputs, plus hand-written flush/reset corner sequences.
module tb_hazard_forward_ctrl;
    import hazard_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic       id_use_rs = 1'b0;
    logic       id_use_rt = 1'b0;
    logic [4:0] id_dest = '0;
    logic       id_reg_write = 1'b0;
    logic       id_mem_read = 1'b0;
    logic       id_branch = 1'b0;
    logic       flush = 1'b0;
    logic       stall;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       id_fwd_a;
    logic       id_fwd_b;

    hazard_forward_ctrl dut (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_branch(id_branch),
        .flush(flush), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .id_fwd_a(id_fwd_a), .id_fwd_b(id_fwd_b)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       flush;
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic [4:0] dest;
        logic       rw;
        logic       mr;
        logic       br;
        logic [6:0] exp;
    } vec_t;

    localparam logic [6:0] E0 = 7'b0;

    vec_t       vecs[$];
    string      vnames[$];
    logic [6:0] exp_q[$];
    string      name_q[$];
    int         checks = 0;
    int         failures = 0;

    // expected output word: {stall, fwd_a, fwd_b, id_fwd_a, id_fwd_b}
    function automatic logic [6:0] e(input logic s, input logic [1:0] fa, input logic [1:0] fb,
                                     input logic ia, input logic ib);
        return {s, fa, fb, ia, ib};
    endfunction

    function automatic vec_t mk(input logic rst, input logic fl, input logic valid,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic use_rs, input logic use_rt, input logic [4:0] dest,
                                input logic rw, input logic mr, input logic br, input logic [6:0] ex);
        vec_t v;
        v.rst = rst; v.flush = fl; v.valid = valid; v.rs = rs; v.rt = rt;
        v.use_rs = use_rs; v.use_rt = use_rt; v.dest = dest;
        v.rw = rw; v.mr = mr; v.br = br; v.exp = ex;
        return v;
    endfunction

    task automatic ins(input string nm, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ur, input logic ut, input logic [4:0] dest,
                       input logic rw, input logic mr, input logic br, input logic [6:0] ex);
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, rs, rt, ur, ut, dest, rw, mr, br, ex));
        vnames.push_back(nm);
    endtask

    task automatic nop(input string nm, input logic [6:0] ex);
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ex));
        vnames.push_back(nm);
    endtask

    task automatic check_out();
        logic [6:0] got;
        logic [6:0] want;
        string      nm;
        got = {stall, fwd_a, fwd_b, id_fwd_a, id_fwd_b};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_underflow got=%b exp=none", got);
        end else begin
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            if (got !== want) begin
                failures++;
                $display("FAIL %s got {stall,fwd_a,fwd_b,id_fwd_a,id_fwd_b}=%b exp=%b", nm, got, want);
            end
        end
    endtask

    // drive one ID slot just after the edge, compare on the falling edge
    task automatic drive(input vec_t v, input string nm);
        @(posedge clock);
        #1;
        reset        = v.rst;
        flush        = v.flush;
        id_valid     = v.valid;
        id_rs        = v.rs;
        id_rt        = v.rt;
        id_use_rs    = v.use_rs;
        id_use_rt    = v.use_rt;
        id_dest      = v.dest;
        id_reg_write = v.rw;
        id_mem_read  = v.mr;
        id_branch    = v.br;
        exp_q.push_back(v.exp);
        name_q.push_back(nm);
        @(negedge clock);
        check_out();
    endtask

    function automatic vec_t rnd(input logic rst);
        return mk(rst, 1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), E0);
    endfunction

    initial begin
        // forwarding from MEM then WB
        ins("fw_add3", 1, 2, 1, 1, 3, 1, 0, 0, E0);
        ins("fw_sub", 3, 8, 1, 1, 9, 1, 0, 0, E0);
        ins("fw_or_mem", 10, 3, 1, 1, 11, 1, 0, 0, e(0, FWD_MEM, FWD_REG, 0, 0));
        nop("fw_or_wb", e(0, FWD_REG, FWD_WB, 0, 0));
        nop("fw_drain", E0);
        // load-use
        ins("lu_lw5", 1, 2, 1, 0, 5, 1, 1, 0, E0);
        ins("lu_add_stall", 5, 2, 1, 1, 12, 1, 0, 0, e(1, FWD_REG, FWD_REG, 0, 0));
        ins("lu_add_held", 5, 2, 1, 1, 12, 1, 0, 0, E0);
        nop("lu_add_in_ex", e(0, FWD_WB, FWD_REG, 0, 0));
        nop("lu_drain", E0);
        // load then branch: two stalls
        ins("bl_lw6", 1, 2, 1, 0, 6, 1, 1, 0, E0);
        ins("bl_beq_s1", 6, 2, 1, 1, 0, 0, 0, 1, e(1, FWD_REG, FWD_REG, 0, 0));
        ins("bl_beq_s2", 6, 2, 1, 1, 0, 0, 0, 1, e(1, FWD_REG, FWD_REG, 0, 0));
        ins("bl_beq_go", 6, 2, 1, 1, 0, 0, 0, 1, E0);
        nop("bl_beq_in_ex", E0);
        nop("bl_drain", E0);
        // ALU then branch: one stall then ID forward
        ins("ba_addi7", 1, 0, 1, 0, 7, 1, 0, 0, E0);
        ins("ba_beq_stall", 2, 7, 1, 1, 0, 0, 0, 1, e(1, FWD_REG, FWD_REG, 0, 0));
        ins("ba_beq_fwd", 2, 7, 1, 1, 0, 0, 0, 1, e(0, FWD_REG, FWD_REG, 0, 1));
        nop("ba_beq_in_ex", e(0, FWD_REG, FWD_WB, 0, 0));
        nop("ba_drain", E0);
        // zero register is never a hazard
        ins("z_add0", 1, 2, 1, 1, 0, 1, 0, 0, E0);
        ins("z_sub_r0", 0, 0, 1, 1, 13, 1, 0, 0, E0);
        ins("z_beq_r0", 0, 0, 1, 1, 0, 0, 0, 1, E0);
        ins("z_lw0", 1, 2, 1, 0, 0, 1, 1, 0, E0);
        ins("z_add_r0", 0, 0, 1, 1, 14, 1, 0, 0, E0);
        nop("z_add_in_ex", E0);
        nop("z_drain", E0);
        // MEM wins over WB
        ins("pr_add4a", 1, 2, 1, 1, 4, 1, 0, 0, E0);
        ins("pr_add4b", 1, 2, 1, 1, 4, 1, 0, 0, E0);
        ins("pr_use4", 4, 2, 1, 1, 14, 1, 0, 0, E0);
        nop("pr_mem_over_wb", e(0, FWD_MEM, FWD_REG, 0, 0));
        nop("pr_drain", E0);
        // unused operands never stall or forward
        ins("un_lw9", 1, 2, 1, 0, 9, 1, 1, 0, E0);
        ins("un_x", 9, 2, 0, 1, 15, 1, 0, 0, E0);
        ins("un_add9", 1, 2, 1, 1, 9, 1, 0, 0, E0);
        ins("un_y", 9, 2, 0, 1, 16, 1, 0, 0, E0);
        nop("un_y_in_ex", E0);
        nop("un_drain", E0);
        // flushed slot never forwards
        ins("fl_add3", 1, 2, 1, 1, 3, 1, 0, 0, E0);
        vecs.push_back(mk(0, 1, 1, 3, 8, 1, 1, 9, 1, 0, 0, E0));
        vnames.push_back("fl_sub_flushed");
        nop("fl_slot_empty", E0);
        nop("fl_drain", E0);

        // reset held with random ID traffic, then first post-reset cycle
        @(posedge clock);
        for (int i = 0; i < 2; i++) drive(rnd(1'b1), "rst_hold");
        drive(rnd(1'b0), "rst_first_cycle");
        for (int i = 0; i < 3; i++) drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E0), "rst_drain");

        for (int i = 0; i < vecs.size(); i++) drive(vecs[i], vnames[i]);

        // flush together with a load-use stall
        drive(mk(0, 0, 1, 1, 2, 1, 0, 5, 1, 1, 0, E0), "fs_lw5");
        drive(mk(0, 1, 1, 5, 2, 1, 1, 12, 1, 0, 0, e(1, FWD_REG, FWD_REG, 0, 0)), "fs_add_flush");
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E0), "fs_bubble");
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E0), "fs_drain");

        // reset during the second branch-load stall
        drive(mk(0, 0, 1, 1, 2, 1, 0, 6, 1, 1, 0, E0), "rm_lw6");
        drive(mk(0, 0, 1, 6, 2, 1, 1, 0, 0, 0, 1, e(1, FWD_REG, FWD_REG, 0, 0)), "rm_beq_s1");
        drive(mk(1, 0, 1, 6, 2, 1, 1, 0, 0, 0, 1, e(1, FWD_REG, FWD_REG, 0, 0)), "rm_beq_s2_reset");
        drive(mk(0, 0, 1, 6, 2, 1, 1, 0, 0, 0, 1, E0), "rm_beq_after_reset");
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E0), "rm_drain");

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d entries exp=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
